// File: rtl/nbr64_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nbr64_ctrl_if
// Brief    : Handshake and PUF-macro signal bundle for nbr64_ctrl.
//            Optional UNSTABLE flag present when NBR64_CTRL_STABILITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface nbr64_ctrl_if #(
    parameter int NUM_EVAL = 5
);
    localparam int CW = $clog2(NUM_EVAL + 1);

    logic          ch_valid;
    logic          ch_ready;
    logic [63:0]   ch_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_bit;
    logic [CW-1:0] ones;
    logic [63:0]   c;
    logic          ring_rst;
    logic          out;

`ifdef NBR64_CTRL_STABILITY_EN
    logic          unstable;

    modport master (
        input  ch_valid, ch_data, rsp_ready, out,
        output ch_ready, rsp_valid, rsp_bit, ones, c, ring_rst, unstable
    );
    modport slave (
        output ch_valid, ch_data, rsp_ready, out,
        input  ch_ready, rsp_valid, rsp_bit, ones, c, ring_rst, unstable
    );
`else
    modport master (
        input  ch_valid, ch_data, rsp_ready, out,
        output ch_ready, rsp_valid, rsp_bit, ones, c, ring_rst
    );
    modport slave (
        output ch_valid, ch_data, rsp_ready, out,
        input  ch_ready, rsp_valid, rsp_bit, ones, c, ring_rst
    );
`endif
endinterface
`default_nettype wire

// File: rtl/nbr64_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nbr64_ctrl
// Brief    : Bistable-ring PUF sequencer: NUM_EVAL reset/settle/sample runs per
//            challenge, majority-voted response. Option: NBR64_CTRL_STABILITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nbr64_ctrl #(
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 16,
    parameter int NUM_EVAL   = 5
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    nbr64_ctrl_if.master bus
);
    localparam int CW     = $clog2(NUM_EVAL + 1);
    localparam int c_pmax = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int c_pw   = $clog2(c_pmax + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RRST   = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sync;
    logic [c_pw-1:0] r_pcnt;
    logic [CW-1:0]   r_eval_cnt;
    logic [CW-1:0]   r_ones;
    logic [63:0]     r_c;
    logic            r_ch_ready;
    logic            r_rsp_valid;
    logic            r_rsp_bit;
    logic            r_ring_rst;
    logic [CW-1:0]   w_ones_next;
    logic            w_eval_last;

    // OUT is asynchronous to clk; only r_sync[1] is ever consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b00;
        else        r_sync <= {r_sync[0], bus.out};
    end

    assign w_ones_next = r_ones + CW'(r_sync[1]);
    assign w_eval_last = (r_eval_cnt == CW'(NUM_EVAL - 1));

`ifdef NBR64_CTRL_STABILITY_EN
    logic r_unstable;
    assign bus.unstable = r_unstable;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pcnt      <= '0;
            r_eval_cnt  <= '0;
            r_ones      <= '0;
            r_c         <= 64'h0;
            r_ch_ready  <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_bit   <= 1'b0;
            r_ring_rst  <= 1'b1;
`ifdef NBR64_CTRL_STABILITY_EN
            r_unstable  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ch_valid && r_ch_ready) begin
                        r_c        <= bus.ch_data;
                        r_ones     <= '0;
                        r_eval_cnt <= '0;
                        r_pcnt     <= '0;
                        r_ch_ready <= 1'b0;
                        r_ring_rst <= 1'b1;
                        r_state    <= S_RRST;
                    end
                end
                S_RRST: begin
                    if (r_pcnt == c_pw'(RST_CYC - 1)) begin
                        r_pcnt     <= '0;
                        r_ring_rst <= 1'b0;
                        r_state    <= S_SETTLE;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_pcnt == c_pw'(SETTLE_CYC - 1)) begin
                        r_pcnt  <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_ones     <= w_ones_next;
                    r_eval_cnt <= r_eval_cnt + 1'b1;
                    r_ring_rst <= 1'b1;
                    if (w_eval_last) begin
                        // Vote on the updated count so the result is ready on entry to DONE.
                        r_rsp_bit   <= (w_ones_next > CW'(NUM_EVAL / 2));
`ifdef NBR64_CTRL_STABILITY_EN
                        r_unstable  <= (w_ones_next != '0) && (w_ones_next != CW'(NUM_EVAL));
`endif
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_RRST;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ch_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ch_ready  <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_ring_rst  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ch_ready  = r_ch_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_bit   = r_rsp_bit;
    assign bus.ones      = r_ones;
    assign bus.c         = r_c;
    assign bus.ring_rst  = r_ring_rst;

endmodule
`default_nettype wire

// File: tb/tb_nbr64_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbr64_ctrl
// Brief    : Self-checking bench for nbr64_ctrl (default and minimal configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbr64_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nbr64_ctrl_if #(.NUM_EVAL(5)) bif ();
    nbr64_ctrl_if #(.NUM_EVAL(1)) b1 ();

    nbr64_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bif.master));
    nbr64_ctrl #(.RST_CYC(1), .SETTLE_CYC(2), .NUM_EVAL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

    // Ring model: on each release of RING_RST the ring settles to the next pattern bit.
    logic [4:0] pat_cur = 5'b0;
    int         pidx    = 0;
    logic       prev_rr = 1'b1;
    always @(negedge clk) begin
        if (bif.ch_ready) begin
            pidx    = 0;
            bif.out = 1'b0;
        end else if (prev_rr && !bif.ring_rst) begin
            bif.out = (pidx < 5) ? pat_cur[pidx] : 1'b0;
            pidx++;
        end
        prev_rr = bif.ring_rst;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One full transaction on the default DUT; entered and left at a negedge in IDLE.
    task automatic txn(input logic [63:0] ch, input logic [4:0] pat, input int hold,
                       input int e_ones, input logic e_bit, input logic e_unst);
        int cyc, rr_bad, c_bad, st_bad;
        chk("idle_ready", bif.ch_ready, 1);
        pat_cur = pat;
        bif.ch_data = ch; bif.ch_valid = 1'b1;
        @(negedge clk);
        bif.ch_valid = 1'b0; bif.ch_data = ~ch;
        chk("c_latched", bif.c, ch);
        chk("busy_ready", bif.ch_ready, 0);
        cyc = 0; rr_bad = 0; c_bad = 0;
        while (!bif.rsp_valid && cyc < 200) begin
            if (bif.ring_rst !== ((cyc % 21) < 4)) rr_bad++;
            if (bif.c !== ch) c_bad++;
            bif.ch_valid = (cyc == 30);
            @(negedge clk); cyc++;
        end
        bif.ch_valid = 1'b0;
        chk("latency", cyc, 105);
        chk("ring_rst_profile_errs", rr_bad, 0);
        chk("c_hold_errs", c_bad, 0);
        chk("rsp_bit", bif.rsp_bit, e_bit);
        chk("ones", bif.ones, e_ones);
`ifdef NBR64_CTRL_STABILITY_EN
        chk("unstable", bif.unstable, e_unst);
`else
        if (e_unst === 1'bx) $display("unexpected X flag");
`endif
        chk("done_ring_rst", bif.ring_rst, 1);
        st_bad = 0;
        for (int i = 0; i < hold; i++) begin
            bif.ch_valid = (i == 1);
            if (bif.rsp_valid !== 1'b1 || bif.rsp_bit !== e_bit || bif.ones !== e_ones[2:0] ||
                bif.ch_ready !== 1'b0 || bif.c !== ch) st_bad++;
            @(negedge clk);
        end
        bif.ch_valid = 1'b0;
        chk("done_hold_errs", st_bad, 0);
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        bif.rsp_ready = 1'b0;
        chk("post_rsp_valid", bif.rsp_valid, 0);
        chk("post_ch_ready", bif.ch_ready, 1);
        chk("post_c", bif.c, ch);
    endtask

    typedef struct {
        logic [63:0] ch;
        logic [4:0]  pat;
        int          hold;
        int          ones;
        logic        rbit;
        logic        unst;
    } vec_t;

    vec_t tv[6];

    task automatic run_small(input logic o, input int e_ones, input logic e_bit);
        int cyc;
        b1.out = o;
        chk("s_idle_ready", b1.ch_ready, 1);
        b1.ch_data = 64'h0123_4567_89AB_CDEF; b1.ch_valid = 1'b1;
        @(negedge clk);
        b1.ch_valid = 1'b0;
        cyc = 0;
        while (!b1.rsp_valid && cyc < 50) begin
            @(negedge clk); cyc++;
        end
        chk("s_latency", cyc, 4);
        chk("s_rsp_bit", b1.rsp_bit, e_bit);
        chk("s_ones", b1.ones, e_ones);
`ifdef NBR64_CTRL_STABILITY_EN
        chk("s_unstable", b1.unstable, 0);
`endif
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        chk("s_post_ready", b1.ch_ready, 1);
    endtask

    initial begin
        int          cyc, eo;
        logic [4:0]  p;
        logic [63:0] ch, ch2;

        tv[0] = '{64'hDEADBEEF_01234567, 5'b11111, 0,  5, 1'b1, 1'b0};
        tv[1] = '{64'h1111_2222_3333_4444, 5'b10101, 20, 3, 1'b1, 1'b1};
        tv[2] = '{64'hFFFF_0000_FFFF_0000, 5'b00100, 3,  1, 1'b0, 1'b1};
        tv[3] = '{64'h0000_0000_0000_0001, 5'b00000, 1,  0, 1'b0, 1'b0};
        tv[4] = '{64'h8000_0000_0000_0000, 5'b01110, 2,  3, 1'b1, 1'b1};
        tv[5] = '{64'hA5A5_5A5A_C3C3_3C3C, 5'b11000, 0,  2, 1'b0, 1'b1};

        rst_n = 1'b0;
        bif.ch_valid = 1'b0; bif.ch_data = 64'h0; bif.rsp_ready = 1'b0;
        b1.ch_valid = 1'b0;  b1.ch_data = 64'h0;  b1.rsp_ready = 1'b0; b1.out = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ch_ready", bif.ch_ready, 1);
        chk("rst_rsp_valid", bif.rsp_valid, 0);
        chk("rst_rsp_bit", bif.rsp_bit, 0);
        chk("rst_ones", bif.ones, 0);
        chk("rst_c", bif.c, 0);
        chk("rst_ring_rst", bif.ring_rst, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_small(1'b0, 0, 1'b0);
        run_small(1'b1, 1, 1'b1);

        for (int i = 0; i < 6; i++)
            txn(tv[i].ch, tv[i].pat, tv[i].hold, tv[i].ones, tv[i].rbit, tv[i].unst);

        for (int i = 0; i < 8; i++) begin
            p  = 5'($urandom);
            ch = {$urandom, $urandom};
            eo = $countones(p);
            txn(ch, p, $urandom_range(0, 4), eo, eo > 2, (eo != 0) && (eo != 5));
        end

        // Back-to-back with RSP_READY tied high.
        ch = 64'h1234_5678_9ABC_DEF0; ch2 = 64'h0FED_CBA9_8765_4321;
        bif.rsp_ready = 1'b1; pat_cur = 5'b11111;
        bif.ch_data = ch; bif.ch_valid = 1'b1;
        @(negedge clk);
        bif.ch_data = ch2;
        cyc = 0;
        while (!bif.rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
        chk("b2b_lat1", cyc, 105);
        chk("b2b_ones1", bif.ones, 5);
        pat_cur = 5'b00000;
        @(negedge clk);
        chk("b2b_idle_ready", bif.ch_ready, 1);
        chk("b2b_idle_c", bif.c, ch);
        @(negedge clk);
        bif.ch_valid = 1'b0;
        chk("b2b_c2", bif.c, ch2);
        cyc = 0;
        while (!bif.rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
        chk("b2b_lat2", cyc, 105);
        chk("b2b_ones2", bif.ones, 0);
        chk("b2b_bit2", bif.rsp_bit, 0);
        @(negedge clk);
        bif.rsp_ready = 1'b0;

        // Asynchronous reset during SETTLE of the third evaluation.
        pat_cur = 5'b11111;
        bif.ch_data = 64'hCAFE_F00D_0BAD_BEEF; bif.ch_valid = 1'b1;
        @(negedge clk);
        bif.ch_valid = 1'b0;
        cyc = 0;
        while (cyc < 50) begin @(negedge clk); cyc++; end
        chk("abort_pre_ring", bif.ring_rst, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ring_rst", bif.ring_rst, 1);
        chk("abort_c", bif.c, 0);
        chk("abort_ch_ready", bif.ch_ready, 1);
        chk("abort_rsp_valid", bif.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(64'hDEADBEEF_01234567, 5'b10101, 0, 3, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nbr64_ctrl.md
Name: nbr64_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 64-stage bistable ring PUF macro and also consumes its output.
- Accepts a 64-bit challenge over a valid/ready handshake and drives the macro's challenge and reset pins.
- Runs NUM_EVAL reset/settle/sample evaluations of the ring, then returns a majority-voted response bit plus the raw ones count over a second valid/ready handshake.

Parameters:
- RST_CYC, 4: cycles RING_RST is held high at the start of each evaluation (min 1).
- SETTLE_CYC, 16: cycles after RING_RST release before sampling (min 2, covers the synchronizer).
- NUM_EVAL, 5: evaluations per challenge; must be odd, range 1..255.
- CW, $clog2(NUM_EVAL+1): width of ONES (derived, not to be overridden).

Ports:
- CLK  input  1  single clock.
- RESET_N  input  1  asynchronous, active-low reset.
- CH_VALID  input  1  challenge request valid.
- CH_READY  output  1  controller can accept a challenge.
- CH_DATA  input  64  challenge.
- RSP_VALID  output  1  response valid.
- RSP_READY  input  1  consumer accepts the response.
- RSP_BIT  output  1  majority-voted PUF response.
- ONES  output  CW  number of evaluations that sampled 1.
- C  output  64  challenge to the PUF macro.
- RING_RST  output  1  reset to the PUF macro, active-high.
- OUT  input  1  asynchronous PUF ring output.

Behaviour:
- Reset (RESET_N low, asynchronous), all registered:
  - State IDLE.
  - CH_READY=1, RSP_VALID=0, RSP_BIT=0, ONES=0.
  - C=64'h0, RING_RST=1.
  - Counters and synchronizer cleared.
- OUT passes through a 2-flop synchronizer (sync reset value 0). Only the second flop is sampled.
- States: IDLE, RRST, SETTLE, SAMPLE, DONE.
- IDLE:
  - CH_READY=1, RING_RST=1.
  - On CH_VALID&CH_READY: latch CH_DATA into C, clear ONES and the evaluation counter, go to RRST.
- RRST:
  - RING_RST=1 for exactly RST_CYC cycles, then go to SETTLE.
- SETTLE:
  - RING_RST=0 for exactly SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - RING_RST=0.
  - ONES += synchronized OUT.
  - Evaluation counter +1.
  - If the counter reaches NUM_EVAL, go to DONE; otherwise go to RRST.
- DONE:
  - RSP_VALID=1, RING_RST=1.
  - RSP_BIT = (final ONES > NUM_EVAL/2), registered on entry to DONE.
  - RSP_BIT and ONES hold stable while RSP_VALID=1 && !RSP_READY.
  - On RSP_READY, go to IDLE. RSP_VALID drops in the next cycle.
- Latency:
  - One evaluation = RST_CYC+SETTLE_CYC+1 cycles.
  - RSP_VALID rises NUM_EVAL*(RST_CYC+SETTLE_CYC+1) cycles after the acceptance edge.
  - With defaults: 105 cycles.
- CH_READY=0 in every state except IDLE. CH_VALID outside IDLE is ignored and nothing is queued.
- C holds the last accepted challenge until the next acceptance. It is never changed mid-evaluation.
- ONES never exceeds NUM_EVAL, and CW guarantees it cannot overflow.
- RESET_N asserted in any state returns to reset values immediately (RING_RST=1 asynchronously). No response is emitted for the aborted challenge.
- RSP_READY is ignored outside DONE.

Optional Feature:
- Macro NBR64_CTRL_STABILITY_EN.
- When defined:
  - Adds output port UNSTABLE (1 bit, reset 0), valid with RSP_VALID.
  - UNSTABLE = 1 when ONES is neither 0 nor NUM_EVAL, i.e. the evaluations disagreed. Registered with RSP_BIT.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Defaults, PUF model OUT=1 constant, challenge 64'hDEADBEEF_01234567 → C equals it from the cycle after acceptance; RSP_VALID rises exactly 105 cycles after acceptance with RSP_BIT=1, ONES=5. RING_RST shows 5 pulses, each 4 cycles high then 17 cycles low.
- PUF model returning 1,0,1,0,1 per evaluation → ONES=3, RSP_BIT=1; UNSTABLE=1 with the macro defined. Pattern 0,0,1,0,0 → ONES=1, RSP_BIT=0.
- RSP_READY held low for 20 cycles in DONE → RSP_VALID, RSP_BIT and ONES stable throughout; CH_READY=0; a CH_VALID pulse during DONE is ignored (C unchanged). RSP_READY=1 → IDLE, CH_READY=1 next cycle.
- RESET_N pulsed low during SETTLE of the 3rd evaluation → RING_RST=1, C=0, CH_READY=1, RSP_VALID=0 with no clock edge. A new challenge after release completes normally in 105 cycles.
- Back-to-back challenges with RSP_READY tied high → second challenge accepted in IDLE one cycle after the first response handshake; ONES restarts from 0 and the second response is independent of the first.
- NUM_EVAL=1, RST_CYC=1, SETTLE_CYC=2, OUT=0 → RSP_VALID 4 cycles after acceptance, RSP_BIT=0, ONES=0, UNSTABLE=0.
